// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern of up to MAX_LEN bits.
// Supports overlapping and non-overlapping matching and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned          MAX_LEN     = 8,
  parameter int unsigned          LEN_W       = 4,
  parameter int unsigned          CNT_W       = 16,
  parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(3'b010),
  parameter logic [LEN_W-1:0]     DEF_LEN     = LEN_W'(3),
  parameter logic                 DEF_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  localparam int unsigned FILL_W = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] history;
  logic [FILL_W-1:0]  fill;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;

  logic [MAX_LEN-1:0] history_shift;
  logic [FILL_W-1:0]  fill_inc;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len_clamped;
  logic               sample;
  logic               match;
  logic [CNT_W-1:0]   count_next;
  logic               sat_next;

  // Candidate history/fill after consuming the current bit, and the match decision.
  always_comb begin
    history_shift = '0;
    fill_inc      = fill;
    mask          = '0;
    sample        = en && !cfg_load;
    match         = 1'b0;
    if (MAX_LEN > 1)
      history_shift = {history[MAX_LEN-2:0], in};
    else
      history_shift[0] = in;
    if (fill != FILL_W'(MAX_LEN))
      fill_inc = fill + FILL_W'(1);
    for (int unsigned i = 0; i < MAX_LEN; i++)
      mask[i] = (i < 32'(len));
    match = sample && (len != '0) && (LEN_W'(fill_inc) >= len) &&
            (((history_shift ^ pattern) & mask) == '0);
  end

  // Clamp an oversized requested length to the history depth.
  always_comb begin
    len_clamped = cfg_len;
    if (32'(cfg_len) > MAX_LEN)
      len_clamped = LEN_W'(MAX_LEN);
  end

  // Counter update: a same-edge clear happens before the match is counted.
  always_comb begin
    count_next = match_count;
    sat_next   = count_sat;
    if (clr_count) begin
      count_next = '0;
      sat_next   = 1'b0;
    end
    if (match && (count_next != '1)) begin
      count_next = count_next + CNT_W'(1);
      if (count_next == '1)
        sat_next = 1'b1;
    end
  end

  // Configuration, history, fill and match pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      history <= '0;
      fill    <= '0;
      pattern <= DEF_PATTERN;
      len     <= DEF_LEN;
      overlap <= DEF_OVERLAP;
      out     <= 1'b0;
    end else if (cfg_load) begin
      pattern <= cfg_pattern;
      len     <= len_clamped;
      overlap <= cfg_overlap;
      history <= '0;
      fill    <= '0;
      out     <= 1'b0;
    end else if (en) begin
      history <= history_shift;
      fill    <= (match && !overlap) ? '0 : fill_inc;
      out     <= match;
    end else begin
      out     <= 1'b0;
    end
  end

  // Saturating match counter and sticky saturation flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      match_count <= count_next;
      count_sat   <= sat_next;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default-width instance plus a 4-bit counter instance.
module tb_seq_detector_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        in;
  logic        cfg_load;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic        clr_count;
  logic        out;
  logic [15:0] match_count;
  logic        count_sat;
  logic        out4;
  logic [3:0]  match_count4;
  logic        count_sat4;

  int checks   = 0;
  int failures = 0;

  seq_detector_param dut (
    .clk(clk), .reset(reset), .en(en), .in(in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .out(out), .match_count(match_count), .count_sat(count_sat)
  );

  seq_detector_param #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .in(in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .out(out4), .match_count(match_count4), .count_sat(count_sat4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic exp_out, input string tag);
    en = 1'b1;
    in = b;
    @(posedge clk);
    #1;
    chk(tag, {31'b0, out}, {31'b0, exp_out});
    en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_out", {31'b0, out}, 32'd0);
    chk("rst_cnt", {16'b0, match_count}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    en          = 1'b1;
    in          = 1'b1;
    @(posedge clk);
    #1;
    chk("load_out", {31'b0, out}, 32'd0);
    cfg_load = 1'b0;
    en       = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; in = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; clr_count = 1'b0;
    #2;
    chk("init_out", {31'b0, out}, 32'd0);
    chk("init_cnt", {16'b0, match_count}, 32'd0);
    chk("init_sat", {31'b0, count_sat}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Default pattern 010, overlapping
    step(0, 0, "ov_b1"); step(1, 0, "ov_b2"); step(0, 1, "ov_b3");
    step(1, 0, "ov_b4"); step(0, 1, "ov_b5");
    chk("ov_cnt", {16'b0, match_count}, 32'd2);

    // Non-overlapping 010
    do_reset();
    load(8'b010, 4'd3, 1'b0);
    step(0, 0, "no_b1"); step(1, 0, "no_b2"); step(0, 1, "no_b3"); step(1, 0, "no_b4");
    step(0, 0, "no_b5"); step(0, 0, "no_b6"); step(1, 0, "no_b7"); step(0, 1, "no_b8");
    chk("no_cnt", {16'b0, match_count}, 32'd2);

    // Full-width pattern A5, then clamped length 12
    do_reset();
    for (int r = 0; r < 2; r++) begin
      load(8'hA5, (r == 0) ? 4'd8 : 4'd12, 1'b1);
      step(1, 0, "a5_b1"); step(1, 0, "a5_b2"); step(0, 0, "a5_b3");
      step(1, 0, "a5_b4"); step(0, 0, "a5_b5"); step(0, 0, "a5_b6");
      step(1, 0, "a5_b7"); step(0, 0, "a5_b8"); step(1, 1, "a5_b9");
      chk("a5_cnt", {16'b0, match_count}, 32'(r + 1));
    end

    // en=0 gaps are ignored
    do_reset();
    step(0, 0, "en_b1"); step(1, 0, "en_b2");
    in = 1'b1;
    @(posedge clk); #1; chk("en_gap1", {31'b0, out}, 32'd0);
    @(posedge clk); #1; chk("en_gap2", {31'b0, out}, 32'd0);
    step(0, 1, "en_b3");
    chk("en_cnt", {16'b0, match_count}, 32'd1);

    // Mid-sequence reset discards progress
    do_reset();
    step(0, 0, "mr_b1"); step(1, 0, "mr_b2");
    do_reset();
    step(0, 0, "mr_b3"); step(1, 0, "mr_b4"); step(0, 1, "mr_b5");
    chk("mr_cnt", {16'b0, match_count}, 32'd1);

    // Length 0 disables matching
    load(8'b010, 4'd0, 1'b1);
    step(0, 0, "z_b1"); step(1, 0, "z_b2"); step(0, 0, "z_b3");
    chk("z_cnt", {16'b0, match_count}, 32'd1);

    // Counter saturation on 4-bit instance, then clear coinciding with a match
    do_reset();
    step(0, 0, "sat_b0");
    for (int m = 1; m <= 16; m++) begin
      step(1, 0, "sat_one");
      step(0, 1, "sat_zero");
      if (m == 14) begin
        chk("sat_c14", {28'b0, match_count4}, 32'd14);
        chk("sat_f14", {31'b0, count_sat4}, 32'd0);
      end
      if (m == 15) chk("sat_f15", {31'b0, count_sat4}, 32'd1);
    end
    chk("sat_cnt4", {28'b0, match_count4}, 32'd15);
    chk("sat_flag4", {31'b0, count_sat4}, 32'd1);
    chk("sat_cnt16", {16'b0, match_count}, 32'd16);
    step(1, 0, "clr_one");
    clr_count = 1'b1;
    step(0, 1, "clr_match_out");
    clr_count = 1'b0;
    chk("clr_cnt4", {28'b0, match_count4}, 32'd1);
    chk("clr_flag4", {31'b0, count_sat4}, 32'd0);
    chk("clr_cnt16", {16'b0, match_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits (2..32).
REQ-002 Parameter LEN_W, default 4: width of cfg_len; SHALL satisfy 2^LEN_W > MAX_LEN.
REQ-003 Parameter CNT_W, default 16: width of match_count.
REQ-004 Parameters DEF_PATTERN, DEF_LEN and DEF_OVERLAP, defaults MAX_LEN'b010, 3 and 1: configuration applied at reset.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  sample enable; in is consumed only on edges where en=1.
REQ-008 in  input  1  serial data bit.
REQ-009 cfg_load  input  1  load cfg_pattern, cfg_len and cfg_overlap on this edge.
REQ-010 cfg_pattern  input  MAX_LEN  pattern bits; the first-received bit is cfg_pattern[len-1] and the last-received bit is cfg_pattern[0].
REQ-011 cfg_len  input  LEN_W  pattern length.
REQ-012 cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
REQ-013 clr_count  input  1  synchronous clear of match_count and count_sat.
REQ-014 out  output  1  registered one-cycle match pulse.
REQ-015 match_count  output  CNT_W  number of matches since reset or clear, saturating.
REQ-016 count_sat  output  1  sticky flag; set when match_count reaches all-ones.

Function
REQ-017 The block SHALL keep a MAX_LEN-bit history shift register and a fill counter (0..MAX_LEN) of valid history bits.
REQ-018 On each edge with en=1 and cfg_load=0: shift in into history bit 0 and increment the fill counter, saturating at MAX_LEN.
REQ-019 A match SHALL occur when all of the following hold: fill (after the shift) >= len; the low len bits of the history equal the low len bits of the stored pattern; len != 0.
REQ-020 out SHALL be 1 for exactly the clock period that follows the edge on which the final pattern bit was sampled; otherwise out = 0.
REQ-021 Overlap mode: after a match, the fill counter is unchanged, so suffix bits can begin the next match ("01010" with pattern 010 gives 2 matches).
REQ-022 Non-overlap mode: on a match, the fill counter SHALL be cleared to 0, so the next match needs len fresh bits.
REQ-023 en=0: in is ignored, history and fill are held, and out = 0 on the next cycle.
REQ-024 cfg_load=1: latch the configuration, clear history and fill, and drive out = 0; in is not sampled on that edge, and cfg_load takes priority over en.
REQ-025 cfg_len > MAX_LEN SHALL be clamped to MAX_LEN when loaded; cfg_len = 0 disables matching (out stays 0).
REQ-026 On each match, match_count SHALL increment by 1; it holds at all-ones instead of wrapping, and count_sat is set at the same edge that match_count reaches all-ones.
REQ-027 clr_count and a match on the same edge: match_count = 1 and count_sat = 0 (the clear is applied first, then the match is counted).
REQ-028 clr_count SHALL NOT affect the history, fill or out.

Reset
REQ-029 While reset=0, the block SHALL asynchronously force: out=0, match_count=0, count_sat=0, history=0, fill=0, pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP.
REQ-030 Reset asserted mid-sequence SHALL discard partial progress; no match may complete using bits received before reset.
REQ-031 The first in sample after reset release SHALL be taken on the first rising edge with reset=1 and en=1.

Verification
REQ-032 Defaults, en=1, stream 0,1,0,1,0 -> out pulses after bits 3 and 5, match_count=2.
REQ-033 Load pattern=010, len=3, overlap=0; stream 0,1,0,1,0,0,1,0 -> out pulses after bits 3 and 8 only, match_count=2.
REQ-034 Load pattern=8'hA5, len=8, overlap=1; stream 1,1,0,1,0,0,1,0,1 -> single pulse after bit 9; repeat with cfg_len=12 -> behaves as len=8.
REQ-035 Defaults; stream 0,1 with en=1, then 2 cycles en=0 (in=1), then 0 with en=1 -> one pulse after the final 0.
REQ-036 Defaults; stream 0,1, then reset low for 1 cycle, then stream 0 -> no pulse; continue with 1,0 -> pulse, match_count=1.
REQ-037 CNT_W=4, defaults, 16 overlapping matches -> match_count=15, count_sat=1; then clr_count coinciding with a match -> match_count=1, count_sat=0.
